// File: rtl/uart_tx_sched_pkg.sv
// Shared UART frame-format codes and the TX scheduler state encoding.
package uart_pkg;

   typedef enum logic [2:0] {
      D5P0 = 3'b000,
      D5P1 = 3'b001,
      D6P0 = 3'b010,
      D6P1 = 3'b011,
      D7P0 = 3'b100,
      D7P1 = 3'b101,
      D8P0 = 3'b110,
      D8P1 = 3'b111
   } umode_t;

   typedef enum logic [1:0] {
      STP_1B  = 2'b00,
      STP_15B = 2'b01,
      STP_2B  = 2'b10
   } smode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_DONE
   } sched_state_t;

   // The reserved stop-bit code falls back to a single stop bit.
   function automatic logic [1:0] smode_legal(input logic [1:0] m);
      return (m == 2'b11) ? 2'(STP_1B) : m;
   endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals shared by the UART TX scheduler.
interface uart_tx_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   REQ_VALID;
   logic [8*N_REQ-1:0] REQ_DATA;
   logic [3*N_REQ-1:0] REQ_UMODE;
   logic [2*N_REQ-1:0] REQ_SMODE;
   logic [N_REQ-1:0]   REQ_ACCEPT;
   logic [N_REQ-1:0]   REQ_DONE;
   logic [N_REQ-1:0]   REQ_ERR;
   logic               TX_START;
   logic [7:0]         TX_DATA;
   logic [2:0]         TX_UMODE;
   logic [1:0]         TX_SMODE;
   logic               TX_BUSY;
   logic               TX_DONE;

   modport master (
      output REQ_VALID, REQ_DATA, REQ_UMODE, REQ_SMODE, TX_BUSY, TX_DONE,
      input  REQ_ACCEPT, REQ_DONE, REQ_ERR, TX_START, TX_DATA, TX_UMODE, TX_SMODE
   );

   modport slave (
      input  REQ_VALID, REQ_DATA, REQ_UMODE, REQ_SMODE, TX_BUSY, TX_DONE,
      output REQ_ACCEPT, REQ_DONE, REQ_ERR, TX_START, TX_DATA, TX_UMODE, TX_SMODE
   );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after rr_ptr.
module uart_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int OW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OW-1:0]    rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [OW-1:0]    grant_idx,
   output logic             any
);
   logic [OW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      // Wrap explicitly at N_REQ so non-power-of-2 counts never land on a missing slot.
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (32'(rr_ptr) + k >= N_REQ)
            cand = OW'(32'(rr_ptr) + k - N_REQ);
         else
            cand = OW'(32'(rr_ptr) + k);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
module uart_tx_sched #(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = 4096,
   localparam int OW      = $clog2(N_REQ)
) (
   input  logic           SCLK,
   input  logic           SCLR_N,
   uart_tx_sched_if.slave bus,
   output logic           BUSY,
   output logic [OW-1:0]  OWNER
);
   import uart_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);

   sched_state_t     state, state_nxt;
   logic [OW-1:0]    rr_ptr, rr_ptr_nxt, owner_nxt, grant_idx;
   logic [N_REQ-1:0] grant;
   logic             any_req;
   logic [TW-1:0]    timer, timer_nxt;
   logic             err, err_nxt;
   logic [7:0]       data_nxt;
   logic [2:0]       umode_nxt;
   logic [1:0]       smode_nxt;
   logic             start_nxt;
   logic [N_REQ-1:0] accept_nxt, done_nxt, rerr_nxt;

   uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req       (bus.REQ_VALID),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   // Next values of every output are decided here so all outputs leave flops.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      timer_nxt  = timer;
      err_nxt    = err;
      owner_nxt  = OWNER;
      data_nxt   = bus.TX_DATA;
      umode_nxt  = bus.TX_UMODE;
      smode_nxt  = bus.TX_SMODE;
      start_nxt  = 1'b0;
      accept_nxt = '0;
      done_nxt   = '0;
      rerr_nxt   = '0;
      case (state)
         S_IDLE: begin
            if (any_req && !bus.TX_BUSY) begin
               state_nxt  = S_START;
               owner_nxt  = grant_idx;
               rr_ptr_nxt = (grant_idx == OW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
               start_nxt  = 1'b1;
               accept_nxt = grant;
               for (int unsigned i = 0; i < N_REQ; i++) begin
                  if (grant[i]) begin
                     data_nxt  = bus.REQ_DATA[8*i +: 8];
                     umode_nxt = bus.REQ_UMODE[3*i +: 3];
                     smode_nxt = smode_legal(bus.REQ_SMODE[2*i +: 2]);
                  end
               end
            end
         end
         S_START: begin
            timer_nxt = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            timer_nxt = timer + 1'b1;
            if (bus.TX_DONE) begin
               err_nxt         = 1'b0;
               state_nxt       = S_DONE;
               done_nxt[OWNER] = 1'b1;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               err_nxt         = 1'b1;
               state_nxt       = S_DONE;
               done_nxt[OWNER] = 1'b1;
               rerr_nxt[OWNER] = 1'b1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge SCLK or negedge SCLR_N) begin
      if (!SCLR_N) begin
         state          <= S_IDLE;
         rr_ptr         <= '0;
         timer          <= '0;
         err            <= 1'b0;
         OWNER          <= '0;
         BUSY           <= 1'b0;
         bus.TX_START   <= 1'b0;
         bus.TX_DATA    <= '0;
         bus.TX_UMODE   <= '0;
         bus.TX_SMODE   <= '0;
         bus.REQ_ACCEPT <= '0;
         bus.REQ_DONE   <= '0;
         bus.REQ_ERR    <= '0;
      end else begin
         state          <= state_nxt;
         rr_ptr         <= rr_ptr_nxt;
         timer          <= timer_nxt;
         err            <= err_nxt;
         OWNER          <= owner_nxt;
         BUSY           <= (state_nxt != S_IDLE);
         bus.TX_START   <= start_nxt;
         bus.TX_DATA    <= data_nxt;
         bus.TX_UMODE   <= umode_nxt;
         bus.TX_SMODE   <= smode_nxt;
         bus.REQ_ACCEPT <= accept_nxt;
         bus.REQ_DONE   <= done_nxt;
         bus.REQ_ERR    <= rerr_nxt;
      end
   end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter among N_REQ requesters. It arbitrates pending requests and latches the winner's byte and frame configuration (UMODE/SMODE). It then issues a one-cycle start to the transmitter, holds the configuration stable for the whole frame, and reports completion or timeout back to the owning requester. It sits between the local bus masters and the UART TX/baud_gen datapath; the RX side uses the same UMODE/SMODE encoding.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 4096, max SCLK cycles from TX_START to TX_DONE before the frame is declared failed
OW, $clog2(N_REQ), owner index width (derived, not overridable)

Ports:
SCLK  in  1  system clock
SCLR_N  in  1  asynchronous active-low reset
REQ_VALID  in  N_REQ  per-requester pending request
REQ_DATA  in  8*N_REQ  per-requester byte; slice i = [8i+7:8i]
REQ_UMODE  in  3*N_REQ  per-requester frame format (000=5N0 … 111=8N1, bit0 = parity enable)
REQ_SMODE  in  2*N_REQ  per-requester stop bits (00=1, 01=1.5, 10=2, 11 reserved)
REQ_ACCEPT  out  N_REQ  one-hot, 1-cycle pulse: request latched
REQ_DONE  out  N_REQ  one-hot, 1-cycle pulse: frame finished
REQ_ERR  out  N_REQ  one-hot, 1-cycle pulse coincident with REQ_DONE on timeout
TX_START  out  1  1-cycle start strobe to transmitter
TX_DATA  out  8  byte to transmit
TX_UMODE  out  3  frame format to transmitter/baud_gen
TX_SMODE  out  2  stop-bit mode to transmitter
TX_BUSY  in  1  transmitter busy
TX_DONE  in  1  transmitter 1-cycle frame-complete pulse
BUSY  out  1  scheduler not in IDLE
OWNER  out  OW  index of current/last granted requester

Behaviour:
- All outputs are registered.
- Reset (SCLR_N=0, asynchronous):
  - state=IDLE, rr_ptr=0, timer=0.
  - All outputs 0.
  - Reset mid-frame aborts silently: no DONE/ERR pulse.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - Grant only when |REQ_VALID and TX_BUSY=0.
  - Winner = first set bit scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - On the granting edge: latch TX_DATA/TX_UMODE/TX_SMODE from the winner's slices, OWNER<=g, rr_ptr<=(g+1) mod N_REQ, state<=START.
  - SMODE 11 is latched as 00.
- START (1 cycle):
  - TX_START=1 and REQ_ACCEPT[OWNER]=1 together.
  - timer<=0, state<=WAIT.
- WAIT:
  - timer increments each cycle.
  - TX_DONE=1 -> err<=0, state<=DONE.
  - timer==TIMEOUT-1 with TX_DONE=0 -> err<=1, state<=DONE.
  - TX_DONE on the timeout cycle counts as success.
- DONE (1 cycle):
  - REQ_DONE[OWNER]=1, REQ_ERR[OWNER]=err.
  - state<=IDLE.
- Timing:
  - Latency from REQ_VALID sampled to TX_START high = 1 cycle.
  - Minimum frame-to-frame spacing = TX duration + 2 cycles (DONE, IDLE).
- Requester rules:
  - Hold REQ_VALID and data/config stable until REQ_ACCEPT.
  - Deasserting before accept is a legal withdrawal.
  - REQ_VALID still high after REQ_ACCEPT is a new request.
- TX_DATA/TX_UMODE/TX_SMODE/OWNER hold from grant through DONE and keep last values in IDLE.
- Inputs from non-owners are ignored while BUSY.
- TX_DONE outside WAIT is ignored.
- BUSY = (state!=IDLE).
- N_REQ not a power of 2: rr_ptr wraps at N_REQ-1 -> 0.

Decomposition:
- Shared package uart_pkg:
  - UMODE codes D5P0..D8P1
  - SMODE codes STP_1B/STP_15B/STP_2B
  - scheduler state enum
- One sub-module: uart_rr_arbiter, combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant one-hot, grant index, any.

Test Plan:
- Single request: REQ_VALID=0001, DATA0=8'hA5, UMODE0=111, SMODE0=00 -> next cycle TX_START=1, REQ_ACCEPT=0001, TX_DATA=A5, TX_UMODE=111; TX_DONE pulse -> REQ_DONE=0001 next cycle, REQ_ERR=0.
- All four requesting continuously, rr_ptr=0 -> grant order 0,1,2,3,0; OWNER sequence 0,1,2,3,0, each REQ_ACCEPT one-hot.
- Config isolation: during requester 1's frame (UMODE=010), change REQ_UMODE1 and REQ_DATA1 -> TX_UMODE stays 010 and TX_DATA unchanged until DONE.
- Timeout: TIMEOUT=16, no TX_DONE -> REQ_DONE and REQ_ERR for owner 17 cycles after TX_START; TX_DONE exactly on timer=15 -> REQ_ERR=0.
- TX_BUSY=1 in IDLE with REQ_VALID=0010 -> no grant until TX_BUSY falls, then TX_START 1 cycle later; SMODE=11 latched as TX_SMODE=00.
- Reset asserted in WAIT -> all outputs 0 immediately, no REQ_DONE; after release with REQ_VALID=1000, first grant goes to requester 3.
